range_window_ctrl: RTL and testbench

- Sequencer for a RangeFinder datapath instance, which it drives and which sits downstream of it.
- Accepts a valid/ready sample stream and groups it into fixed-length windows of WINDOW_LEN samples.
- Per window: issues go/finish to the RangeFinder, waits for the result, then presents range plus error as one record on a valid/ready output.
- Sits between the pin-level sample source and the result consumer (uo_out / uio_out mapping in the top level).

---
 rtl/range_window_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_range_window_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_window_ctrl.sv
// range_window_ctrl: groups a valid/ready sample stream into windows of
// WINDOW_LEN samples, drives go/finish on a RangeFinder instance and returns
// one {range, error, count} record per window on a valid/ready output.
// Optional build macro WINDOW_TIMEOUT_EN: closes a window after TIMEOUT cycles
// without an accepted sample and flags the record as errored.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no window open; first accepted sample opens one
// RUN   | window open; accepting samples until full, flush or timeout
// FIN   | rf_finish pulse (delayed one cycle if rf_go is still high)
// WAIT  | counting down RESULT_LAT cycles for the RangeFinder result
// OUT   | result record presented, held until out_ready
module range_window_ctrl #(
    parameter int WIDTH      = 8,
    parameter int WINDOW_LEN = 16,
    parameter int RESULT_LAT = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic [WIDTH-1:0] out_range,
    output logic             out_error,
    output logic [7:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    if (WINDOW_LEN < 2 || WINDOW_LEN > 255) begin : g_bad_window_len
        $error("range_window_ctrl: WINDOW_LEN must be 2..255");
    end
    if (RESULT_LAT < 1 || RESULT_LAT > 7) begin : g_bad_result_lat
        $error("range_window_ctrl: RESULT_LAT must be 1..7");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("range_window_ctrl: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [7:0] WIN_LAST = 8'(WINDOW_LEN - 1);
    localparam logic [2:0] LAT_LOAD = 3'(RESULT_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [2:0] lat_cnt;
    logic       accept;
    logic       timeout_hit;
    logic       timeout_flag;

    assign in_ready = !reset && (state == S_IDLE || state == S_RUN);
    assign accept   = in_valid && in_ready;

`ifdef WINDOW_TIMEOUT_EN
    // Loaded so that the forced rf_finish lands TIMEOUT cycles after the
    // last accepted sample (one cycle of that is the FIN transition itself).
    localparam logic [15:0] IDLE_LOAD = 16'(TIMEOUT - 2);

    logic [15:0] idle_cnt;

    assign timeout_hit = (state == S_RUN) && !accept && (idle_cnt == 16'd0);

    // Idle down-counter restarted by every accepted sample; sticky timeout bit per window.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (accept) begin
                idle_cnt <= IDLE_LOAD;
            end else if (state == S_RUN && idle_cnt != 16'd0) begin
                idle_cnt <= idle_cnt - 16'd1;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end else if (state == S_IDLE && accept) begin
                timeout_flag <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        rf_finish = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = flush ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (flush || timeout_hit || (accept && cnt == WIN_LAST)) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                // A one-sample window reaches FIN while rf_go is still high;
                // finish waits one cycle so go and finish never coincide.
                rf_finish = !rf_go;
                if (!rf_go) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == 3'd1) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample path, window counter, latency timer and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_data   <= '0;
            rf_go     <= 1'b0;
            cnt       <= 8'd0;
            lat_cnt   <= 3'd0;
            out_range <= '0;
            out_error <= 1'b0;
            out_count <= 8'd0;
        end else begin
            rf_go <= (state == S_IDLE) && accept;
            if (accept) begin
                rf_data <= in_data;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt <= 8'd1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FIN: begin
                    lat_cnt <= LAT_LOAD;
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        out_range <= rf_range;
                        out_error <= rf_error | (cnt < 8'd2) | timeout_flag;
                        out_count <= cnt;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        cnt <= 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_window_ctrl.sv
// Bench for range_window_ctrl with a behavioural RangeFinder (min/max tracker,
// result one cycle after finish) and a scoreboard of expected records.
module tb_range_window_ctrl;

    localparam int WIDTH = 8;
    localparam int WLEN  = 16;
    localparam int LAT   = 1;
    localparam int TMO   = 64;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic             rf_error;
    logic [WIDTH-1:0] out_range;
    logic             out_error;
    logic [7:0]       out_count;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    range_window_ctrl #(
        .WIDTH(WIDTH), .WINDOW_LEN(WLEN), .RESULT_LAT(LAT), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error),
        .out_range(out_range), .out_error(out_error), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int rng;
        int err;
        int cnt;
    } rec_t;

    rec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // RangeFinder model: tracks min/max of rf_data from go through finish.
    int mn, mx;
    bit rf_act = 1'b0;
    bit rf_err_inj = 1'b0;
    always @(posedge clock) begin
        if (reset) begin
            rf_act = 1'b0;
            rf_range <= '0;
            rf_error <= 1'b0;
        end else begin
            if (rf_go) begin
                mn = int'(rf_data);
                mx = int'(rf_data);
                rf_act = 1'b1;
            end else if (rf_act) begin
                if (int'(rf_data) < mn) mn = int'(rf_data);
                if (int'(rf_data) > mx) mx = int'(rf_data);
            end
            if (rf_finish && rf_act) begin
                rf_range <= 8'(mx - mn);
                rf_error <= rf_err_inj;
                rf_act = 1'b0;
            end
        end
    end

    // Monitor: event timestamps, go/finish exclusivity, scoreboard compare.
    int  acc_cnt = 0, last_acc_cyc = 0, first_acc_cyc = 0;
    int  go_cnt = 0, go_cyc = 0, fin_cnt = 0, fin_cyc = 0, ov_cyc = 0;
    bit  prev_ov = 1'b0;
    always @(negedge clock) begin
        rec_t e;
        if (!reset) begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (!busy) first_acc_cyc = cyc;
            end
            if (rf_go) begin go_cnt++; go_cyc = cyc; end
            if (rf_finish) begin fin_cnt++; fin_cyc = cyc; end
            if (rf_go || rf_finish) chk_eq("go_fin_excl", int'(rf_go & rf_finish), 0);
            if (out_valid && !prev_ov) ov_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk_eq("unexpected_out", int'(out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk_eq("out_range", int'(out_range), e.rng);
                    chk_eq("out_error", int'(out_error), e.err);
                    chk_eq("out_count", int'(out_count), e.cnt);
                end
            end
            prev_ov = out_valid;
        end
    end

    // Offer one sample (optionally with flush) until accepted; returns at posedge+1.
    task automatic send(input int d, input bit fl);
        int n = 0;
        in_data  = 8'(d);
        in_valid = 1'b1;
        flush    = fl;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) chk_eq("accept_timeout", int'(in_ready), 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Push the expected record, then drive the window with an optional idle gap.
    task automatic run_window(input int vals[$], input bit fl, input int gap_at, input int gap_len);
        rec_t e;
        int lo = 255, hi = 0;
        foreach (vals[i]) begin
            if (vals[i] < lo) lo = vals[i];
            if (vals[i] > hi) hi = vals[i];
        end
        e.rng = hi - lo;
        e.cnt = vals.size();
        e.err = ((vals.size() < 2) || rf_err_inj) ? 1 : 0;
        sb.push_back(e);
        foreach (vals[i]) begin
            send(vals[i], fl && (i == vals.size() - 1));
            if (i == gap_at) begin
                repeat (gap_len) begin
                    @(negedge clock);
                    chk_eq("rf_data_hold", int'(rf_data), vals[i]);
                    @(posedge clock);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            n++;
            @(negedge clock);
        end
        if (sb.size() != 0) chk_eq("drain_timeout", sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[$];
        int g0, f0, a0, len, n;
        rec_t e;
        in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // Reset values.
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_eq("rst_in_ready", int'(in_ready), 0);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_rf_go", int'(rf_go), 0);
        chk_eq("rst_rf_finish", int'(rf_finish), 0);
        chk_eq("rst_out_valid", int'(out_valid), 0);
        chk_eq("rst_rf_data", int'(rf_data), 0);
        chk_eq("rst_out_range", int'(out_range), 0);
        chk_eq("rst_out_error", int'(out_error), 0);
        chk_eq("rst_out_count", int'(out_count), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk_eq("idle_in_ready", int'(in_ready), 1);
        @(posedge clock); #1;

        // Flush without a sample in IDLE does nothing.
        flush = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk_eq("idle_flush_ignored", int'(busy), 0);
        @(posedge clock); #1;
        flush = 1'b0;

        // Full back-to-back window.
        g0 = go_cnt; f0 = fin_cnt;
        v = '{10, 3, 200, 7, 50, 120, 3, 99, 180, 200, 15, 64, 33, 128, 77, 91};
        run_window(v, 1'b0, -1, 0);
        wait_drain(100);
        chk_eq("full_go_pulses", go_cnt - g0, 1);
        chk_eq("full_fin_pulses", fin_cnt - f0, 1);
        chk_eq("full_go_lat", go_cyc - first_acc_cyc, 1);
        chk_eq("full_fin_lat", fin_cyc - last_acc_cyc, 1);
        chk_eq("full_out_lat", ov_cyc - fin_cyc, LAT + 1);

        // Window with an idle gap after the 5th sample.
        v = {};
        for (int i = 50; i <= 65; i++) v.push_back(i);
        run_window(v, 1'b0, 4, 3);
        wait_drain(100);

        // Flush with the 4th sample.
        v = '{9, 1, 30, 4};
        run_window(v, 1'b1, -1, 0);
        wait_drain(100);
        chk_eq("flush4_fin_lat", fin_cyc - last_acc_cyc, 1);

        // One-sample window.
        v = '{77};
        run_window(v, 1'b1, -1, 0);
        wait_drain(100);
        chk_eq("single_go_lat", go_cyc - last_acc_cyc, 1);
        chk_eq("single_fin_after_go", int'(fin_cyc > go_cyc), 1);

        // Back-pressure on the result, with the RangeFinder reporting an error.
        out_ready  = 1'b0;
        rf_err_inj = 1'b1;
        v = {};
        for (int i = 0; i < WLEN; i++) v.push_back($urandom_range(0, 255));
        run_window(v, 1'b0, -1, 0);
        n = 0;
        @(negedge clock);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clock);
        end
        chk_eq("bp_out_valid_seen", int'(out_valid), 1);
        e = sb[0];
        in_valid = 1'b1;
        in_data  = 8'hAA;
        a0 = acc_cnt;
        repeat (10) begin
            @(negedge clock);
            chk_eq("bp_out_valid", int'(out_valid), 1);
            chk_eq("bp_out_range", int'(out_range), e.rng);
            chk_eq("bp_out_error", int'(out_error), e.err);
            chk_eq("bp_out_count", int'(out_count), e.cnt);
            chk_eq("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        chk_eq("bp_no_accept", acc_cnt - a0, 0);
        out_ready = 1'b1;
        wait_drain(50);
        rf_err_inj = 1'b0;

        // Reset in RUN after 6 samples abandons the window.
        for (int i = 0; i < 6; i++) send(i * 20 + 5, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk_eq("midrst_busy", int'(busy), 0);
        chk_eq("midrst_rf_go", int'(rf_go), 0);
        chk_eq("midrst_rf_finish", int'(rf_finish), 0);
        chk_eq("midrst_out_valid", int'(out_valid), 0);
        chk_eq("midrst_out_count", int'(out_count), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        v = {};
        for (int i = 0; i < WLEN; i++) v.push_back($urandom_range(0, 255));
        run_window(v, 1'b0, -1, 0);
        wait_drain(100);

        // Random back-to-back windows of random length, flushed when short.
        for (int w = 0; w < 6; w++) begin
            len = $urandom_range(1, WLEN);
            v = {};
            for (int i = 0; i < len; i++) v.push_back($urandom_range(0, 255));
            run_window(v, len < WLEN, $urandom_range(0, len - 1), $urandom_range(0, 3));
        end
        wait_drain(400);

`ifdef WINDOW_TIMEOUT_EN
        // Idle window is closed by the timeout and flagged.
        v = '{20, 40, 25};
        run_window(v, 1'b0, -1, 0);
        sb[0].err = 1;
        wait_drain(300);
        chk_eq("timeout_fin_lat", fin_cyc - last_acc_cyc, TMO);
`else
        // Without the timeout an idle window stays open until flushed.
        v = '{20, 40, 25};
        f0 = fin_cnt;
        run_window(v, 1'b0, -1, 0);
        repeat (100) @(posedge clock);
        @(negedge clock);
        chk_eq("no_timeout_busy", int'(busy), 1);
        chk_eq("no_timeout_fin", fin_cnt - f0, 0);
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        wait_drain(50);
        chk_eq("run_flush_fin", fin_cnt - f0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
